// File: rtl/matrix_scan_ctrl.sv
// Row/column scan controller for a 5x7 LED matrix. Shows a scrollable 5-column
// window into a double-buffered message store, in the display mode set by the switches.
module matrix_scan_ctrl #(
  parameter int SCAN_DIV      = 1000,
  parameter int BLANK_CYC     = 2,
  parameter int SCROLL_FRAMES = 50,
  parameter int MSG_LEN       = 16,
  parameter int ADDR_W        = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ala1,
  input  logic              ala2,
  input  logic              msg_we,
  input  logic [ADDR_W-1:0] msg_addr,
  input  logic [6:0]        msg_data,
  output logic [6:0]        row,
  output logic [4:0]        col,
  output logic              frame_tick,
  output logic [ADDR_W-1:0] scroll_pos
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FCNT_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYC);
  localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(SCROLL_FRAMES - 1);
  localparam logic [ADDR_W-1:0]  POS_LAST   = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]    MSG_LEN_X  = (ADDR_W+1)'(MSG_LEN);

  typedef enum logic [1:0] {
    MODE_BLANK  = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_STATIC = 2'b11
  } mode_t;

  mode_t mode, mode_n;
  logic [1:0] sync1, sync2, samp;

  logic [PRESC_W-1:0] presc, presc_n;
  logic [2:0]         row_idx, row_idx_n;
  logic [FCNT_W-1:0]  fcnt, fcnt_n;
  logic [ADDR_W-1:0]  scroll_n;
  logic               dirty, dirty_n;
  logic [MSG_LEN-1:0][6:0] shadow, active, active_n;

  logic              tick, boundary, wr_ok;
  logic [ADDR_W:0]   win_idx;
  logic [6:0]        row_n;
  logic [4:0]        col_n;

  assign tick     = (presc == PRESC_LAST);
  assign boundary = tick && (row_idx == 3'd6);
  assign wr_ok    = msg_we && ({1'b0, msg_addr} < MSG_LEN_X);

  // Mode state register; switch samples are only taken at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      samp  <= '0;
      mode  <= MODE_BLANK;
    end else begin
      sync1 <= {ala2, ala1};
      sync2 <= sync1;
      if (boundary)
        samp <= sync2;
      mode <= mode_n;
    end
  end

  always_comb begin
    presc_n   = tick ? '0 : presc + 1'b1;
    row_idx_n = row_idx;
    if (tick)
      row_idx_n = (row_idx == 3'd6) ? 3'd0 : row_idx + 3'd1;
    mode_n    = mode;
    fcnt_n    = fcnt;
    scroll_n  = scroll_pos;
    dirty_n   = dirty;
    active_n  = active;
    if (boundary && (sync2 == samp))
      mode_n = mode_t'(sync2);
    // Buffer swap, mode change and scroll step all land on the same boundary.
    if (boundary) begin
      if (dirty) begin
        active_n = shadow;
        dirty_n  = 1'b0;
      end
      if (mode_n == MODE_STATIC) begin
        scroll_n = '0;
        fcnt_n   = '0;
      end else if (mode_n != mode) begin
        fcnt_n = '0;
      end else if (mode == MODE_LEFT || mode == MODE_RIGHT) begin
        if (fcnt == FCNT_LAST) begin
          fcnt_n = '0;
          if (mode == MODE_LEFT)
            scroll_n = (scroll_pos == POS_LAST) ? '0 : scroll_pos + 1'b1;
          else
            scroll_n = (scroll_pos == '0) ? POS_LAST : scroll_pos - 1'b1;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
    end
    if (wr_ok)
      dirty_n = 1'b1;
  end

  always_comb begin
    row_n   = '0;
    col_n   = '0;
    win_idx = '0;
    if (mode_n != MODE_BLANK) begin
      if (presc_n >= BLANK_END)
        row_n = 7'b0000001 << row_idx_n;
      for (int k = 0; k < 5; k++) begin
        win_idx = {1'b0, scroll_n} + (ADDR_W+1)'(k);
        if (win_idx >= MSG_LEN_X)
          win_idx = win_idx - MSG_LEN_X;
        col_n[k] = active_n[win_idx[ADDR_W-1:0]][row_idx_n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      row_idx    <= '0;
      fcnt       <= '0;
      scroll_pos <= '0;
      dirty      <= 1'b0;
      active     <= '0;
      row        <= '0;
      col        <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= presc_n;
      row_idx    <= row_idx_n;
      fcnt       <= fcnt_n;
      scroll_pos <= scroll_n;
      dirty      <= dirty_n;
      active     <= active_n;
      row        <= row_n;
      col        <= col_n;
      frame_tick <= boundary;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (wr_ok)
      shadow[msg_addr] <= msg_data;
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: a frame-level model checked every cycle, plus
// hand-computed expectations at chosen points of each display mode.
module tb_matrix_scan_ctrl;

  localparam int SCAN_DIV      = 4;
  localparam int BLANK_CYC     = 1;
  localparam int SCROLL_FRAMES = 2;
  localparam int MSG_LEN       = 16;
  localparam int ADDR_W        = 4;
  localparam int FRAME         = 7 * SCAN_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ala1 = 1'b1;
  logic              ala2 = 1'b1;
  logic              msg_we = 1'b0;
  logic [ADDR_W-1:0] msg_addr = '0;
  logic [6:0]        msg_data = '0;
  logic [6:0]        row;
  logic [4:0]        col;
  logic              frame_tick;
  logic [ADDR_W-1:0] scroll_pos;

  int checks = 0;
  int errors = 0;

  // Model state: time since reset release, mode, window offset, buffers.
  int       t_m, mode_m, prev_samp, fm, scroll_m, d1, d2;
  bit       dirty_m;
  logic [6:0] shadow_m [MSG_LEN];
  logic [6:0] active_m [MSG_LEN];

  matrix_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .SCROLL_FRAMES(SCROLL_FRAMES),
    .MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ala1(ala1), .ala2(ala2),
    .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
    .row(row), .col(col), .frame_tick(frame_tick), .scroll_pos(scroll_pos)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    t_m = 0; mode_m = 0; prev_samp = 0; fm = 0; scroll_m = 0; d1 = 0; d2 = 0;
    dirty_m = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
  endtask

  task automatic modelStep();
    int s, newm;
    s  = d2;
    d2 = d1;
    d1 = {30'd0, ala2, ala1};
    if (t_m % FRAME == FRAME - 1) begin
      newm = (s == prev_samp) ? s : mode_m;
      prev_samp = s;
      if (dirty_m) begin
        active_m = shadow_m;
        dirty_m  = 1'b0;
      end
      fm = (newm != mode_m) ? 0 : fm + 1;
      if (newm == 3)
        scroll_m = 0;
      else if (newm == mode_m && fm % SCROLL_FRAMES == 0 && newm == 1)
        scroll_m = (scroll_m + 1) % MSG_LEN;
      else if (newm == mode_m && fm % SCROLL_FRAMES == 0 && newm == 2)
        scroll_m = (scroll_m + MSG_LEN - 1) % MSG_LEN;
      mode_m = newm;
    end
    if (msg_we && int'(msg_addr) < MSG_LEN) begin
      shadow_m[msg_addr] = msg_data;
      dirty_m = 1'b1;
    end
    t_m++;
  endtask

  function automatic logic [6:0] modelRow();
    logic [6:0] r;
    r = '0;
    if (mode_m != 0 && (t_m % SCAN_DIV) >= BLANK_CYC)
      r[(t_m / SCAN_DIV) % 7] = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] modelCol();
    logic [4:0] c;
    c = '0;
    if (mode_m != 0)
      for (int k = 0; k < 5; k++)
        c[k] = active_m[(scroll_m + k) % MSG_LEN][(t_m / SCAN_DIV) % 7];
    return c;
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("row_in_reset", {25'd0, row}, 32'd0);
        checkOutput("col_in_reset", {27'd0, col}, 32'd0);
        checkOutput("tick_in_reset", {31'd0, frame_tick}, 32'd0);
      end else begin
        checkOutput("row_model", {25'd0, row}, {25'd0, modelRow()});
        checkOutput("col_model", {27'd0, col}, {27'd0, modelCol()});
        checkOutput("tick_model", {31'd0, frame_tick},
                    (t_m > 0 && t_m % FRAME == 0) ? 32'd1 : 32'd0);
        checkOutput("scroll_model", {28'd0, scroll_pos}, scroll_m);
      end
    end
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [6:0] data);
    msg_addr = addr;
    msg_data = data;
    msg_we   = 1'b1;
    @(negedge clk);
    msg_we   = 1'b0;
  endtask

  task automatic setMode(input logic [1:0] m);
    {ala2, ala1} = m;
  endtask

  task automatic gotoPhase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((t_m % FRAME) != p && n < 64);
    if ((t_m % FRAME) != p) begin
      checks++;
      errors++;
      $display("[TB] FAIL gotoPhase: got phase %0d expected %0d", t_m % FRAME, p);
    end
  endtask

  task automatic framesAt2(input int n);
    for (int i = 0; i < n; i++) gotoPhase(2);
  endtask

  initial begin
    logic [6:0] pattern [5];
    int guard;
    pattern[0] = 7'h7F; pattern[1] = 7'h00; pattern[2] = 7'h7F;
    pattern[3] = 7'h00; pattern[4] = 7'h7F;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_row", {25'd0, row}, 32'd0);
    checkOutput("rst_col", {27'd0, col}, 32'd0);
    checkOutput("rst_tick", {31'd0, frame_tick}, 32'd0);
    checkOutput("rst_scroll", {28'd0, scroll_pos}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Static pattern: blank until mode sampled twice, then 10101 in every row
    for (int i = 0; i < 5; i++) applyStimulus(ADDR_W'(i), pattern[i]);
    gotoPhase(0);
    checkOutput("f1_tick", {31'd0, frame_tick}, 32'd1);
    gotoPhase(2);
    checkOutput("f1_blank_row", {25'd0, row}, 32'd0);
    gotoPhase(0);
    checkOutput("f2_tick", {31'd0, frame_tick}, 32'd1);
    checkOutput("f2_row_blanked", {25'd0, row}, 32'd0);
    gotoPhase(2);
    checkOutput("static_row0", {25'd0, row}, 32'h01);
    checkOutput("static_col0", {27'd0, col}, 32'h15);
    gotoPhase(4);
    checkOutput("static_ghost", {25'd0, row}, 32'd0);
    gotoPhase(6);
    checkOutput("static_row1", {25'd0, row}, 32'h02);
    gotoPhase(26);
    checkOutput("static_row6", {25'd0, row}, 32'h40);

    // Scroll left, including the window wrapping across the message end
    gotoPhase(2);
    setMode(2'b01);
    applyStimulus(4'd15, 7'h01);
    framesAt2(3);
    checkOutput("left_pre_step", {28'd0, scroll_pos}, 32'd0);
    framesAt2(1);
    checkOutput("left_step1", {28'd0, scroll_pos}, 32'd1);
    checkOutput("left_col_at1", {27'd0, col}, 32'h0A);
    guard = 0;
    while (scroll_m != 15 && guard < 40) begin gotoPhase(2); guard++; end
    checkOutput("left_at15", {28'd0, scroll_pos}, 32'd15);
    checkOutput("window_wrap_col", {27'd0, col}, 32'h0B);
    guard = 0;
    while (scroll_m != 0 && guard < 4) begin gotoPhase(2); guard++; end
    checkOutput("left_wrap0", {28'd0, scroll_pos}, 32'd0);
    checkOutput("left_col_at0", {27'd0, col}, 32'h15);

    // Scroll right from 0 wraps to MSG_LEN-1
    setMode(2'b10);
    framesAt2(3);
    checkOutput("right_pre_step", {28'd0, scroll_pos}, 32'd0);
    framesAt2(1);
    checkOutput("right_wrap15", {28'd0, scroll_pos}, 32'd15);

    // Static entry zeroes the offset; a short blank pulse is ignored
    setMode(2'b11);
    framesAt2(2);
    checkOutput("static_reentry_scroll", {28'd0, scroll_pos}, 32'd0);
    checkOutput("static_reentry_row", {25'd0, row}, 32'h01);
    gotoPhase(20);
    setMode(2'b00);
    gotoPhase(8);
    setMode(2'b11);
    gotoPhase(14);
    checkOutput("pulse_ignored_row3", {25'd0, row}, 32'h08);
    framesAt2(2);
    checkOutput("pulse_ignored_row0", {25'd0, row}, 32'h01);
    setMode(2'b00);
    framesAt2(2);
    gotoPhase(6);
    checkOutput("blank_row", {25'd0, row}, 32'd0);
    checkOutput("blank_col", {27'd0, col}, 32'd0);

    // Write on the boundary cycle shows up one frame late
    setMode(2'b11);
    framesAt2(2);
    checkOutput("resume_col", {27'd0, col}, 32'h15);
    gotoPhase(27);
    applyStimulus(4'd4, 7'h00);
    gotoPhase(2);
    checkOutput("boundary_write_hidden", {27'd0, col}, 32'h15);
    gotoPhase(2);
    checkOutput("boundary_write_shown", {27'd0, col}, 32'h05);

    // Asynchronous reset mid-row 3
    gotoPhase(14);
    checkOutput("pre_reset_row3", {25'd0, row}, 32'h08);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_row", {25'd0, row}, 32'd0);
    checkOutput("async_rst_col", {27'd0, col}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    gotoPhase(2);
    checkOutput("post_rst_f0_row", {25'd0, row}, 32'd0);
    gotoPhase(2);
    checkOutput("post_rst_f1_row", {25'd0, row}, 32'd0);
    gotoPhase(2);
    checkOutput("post_rst_f2_row", {25'd0, row}, 32'h01);
    checkOutput("post_rst_f2_col", {27'd0, col}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
